// File: rtl/lutram_fifo32_if.sv
// lutram_fifo32_if
// Groups the write side, the registered pop handshake and the status flags of
// lutram_fifo32 into one bundle.
//   slave  modport : the FIFO (takes WR_EN/WR_DATA/DOUT_RDY, drives the rest)
//   master modport : the user (drives WR_EN/WR_DATA/DOUT_RDY, observes the rest)
// Handshake: a word is written when WR_EN && !FULL. A word leaves when
// DOUT_VLD && DOUT_RDY at a rising edge. While DOUT_VLD && !DOUT_RDY, DOUT and
// DOUT_VLD stay stable.
// Signals: WR_EN, WR_DATA[DATA_W], FULL, OVERFLOW, DOUT[DATA_W], DOUT_VLD,
//          DOUT_RDY, LEVEL[6], ALMOST_FULL, ALMOST_EMPTY.
interface lutram_fifo32_if #(
  parameter int DATA_W = 8
);
  logic              WR_EN;
  logic [DATA_W-1:0] WR_DATA;
  logic              FULL;
  logic              OVERFLOW;
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_VLD;
  logic              DOUT_RDY;
  logic [5:0]        LEVEL;
  logic              ALMOST_FULL;
  logic              ALMOST_EMPTY;

  modport slave (
    input  WR_EN, WR_DATA, DOUT_RDY,
    output FULL, OVERFLOW, DOUT, DOUT_VLD, LEVEL, ALMOST_FULL, ALMOST_EMPTY
  );

  modport master (
    output WR_EN, WR_DATA, DOUT_RDY,
    input  FULL, OVERFLOW, DOUT, DOUT_VLD, LEVEL, ALMOST_FULL, ALMOST_EMPTY
  );
endinterface

// File: rtl/lutram_fifo32.sv
// lutram_fifo32
// 32-entry FIFO on distributed-RAM style storage (synchronous write,
// asynchronous read) followed by a registered output stage. The capacity is
// 33 words: 32 in RAM plus 1 in the output register.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous, active-high reset (memory contents are kept)
//   bus  : lutram_fifo32_if.slave (write side, pop handshake, status)
// Optional feature: define LUTRAM_FIFO_PROG_FLAGS_EN to get registered
// ALMOST_FULL (LEVEL >= AF_THR) and ALMOST_EMPTY (LEVEL <= AE_THR). When the
// macro is undefined both flags are tied to 0.
module lutram_fifo32 #(
  parameter int DATA_W = 8,
  parameter int AF_THR = 30,
  parameter int AE_THR = 2
) (
  input logic             CLK,
  input logic             RST,
  lutram_fifo32_if.slave  bus
);

  logic [DATA_W-1:0] mem_q [32];

  logic [4:0]        wr_ptr_q, wr_ptr_d;
  logic [4:0]        rd_ptr_q, rd_ptr_d;
  logic [5:0]        ram_cnt_q, ram_cnt_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic [5:0]        level_q, level_d;

  logic accept, reject, pop, load;

  // FULL is a register that mirrors ram_cnt==32, so using it here is the same
  // as looking at ram_cnt at the start of the cycle. A same-cycle pop never
  // frees a slot for the write.
  assign accept = bus.WR_EN && !full_q;
  assign reject = bus.WR_EN && full_q;
  assign pop    = dout_vld_q && bus.DOUT_RDY;
  // The output register refills whenever it is empty or being emptied.
  assign load   = (ram_cnt_q != 6'd0) && (!dout_vld_q || bus.DOUT_RDY);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    if (accept) wr_ptr_d = wr_ptr_q + 5'd1;
    if (load) begin
      dout_d     = mem_q[rd_ptr_q];
      dout_vld_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + 5'd1;
    end else if (pop) begin
      dout_vld_d = 1'b0;
    end
    ram_cnt_d  = ram_cnt_q + {5'd0, accept} - {5'd0, load};
    full_d     = (ram_cnt_d == 6'd32);
    overflow_d = reject;
    level_d    = ram_cnt_d + {5'd0, dout_vld_d};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      level_q    <= level_d;
    end
  end

  // Storage has no reset so it maps onto LUT RAM; contents survive RST.
  always_ff @(posedge CLK) begin
    if (accept) mem_q[wr_ptr_q] <= bus.WR_DATA;
  end

  assign bus.FULL     = full_q;
  assign bus.OVERFLOW = overflow_q;
  assign bus.DOUT     = dout_q;
  assign bus.DOUT_VLD = dout_vld_q;
  assign bus.LEVEL    = level_q;

`ifdef LUTRAM_FIFO_PROG_FLAGS_EN
  logic af_q, ae_q;

  // Flags follow level_d so they change on the same edge as LEVEL.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (level_d >= 6'(AF_THR));
      ae_q <= (level_d <= 6'(AE_THR));
    end
  end

  assign bus.ALMOST_FULL  = af_q;
  assign bus.ALMOST_EMPTY = ae_q;
`else
  // Thresholds appear only in constant expressions that fold to 0.
  assign bus.ALMOST_FULL  = 1'b0 & (AF_THR > 0);
  assign bus.ALMOST_EMPTY = 1'b0 & (AE_THR >= 0);
`endif

endmodule

// File: tb/tb_lutram_fifo32.sv
module tb_lutram_fifo32;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lutram_fifo32_if #(.DATA_W(W)) bus ();

  lutram_fifo32 #(.DATA_W(W), .AF_THR(30), .AE_THR(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after posedge, so at negedge the handshake for the
  // coming edge is settled: a visible DOUT_VLD && DOUT_RDY is a pop.
  always @(negedge clk) begin
    if (!rst && bus.DOUT_VLD === 1'b1 && bus.DOUT_RDY === 1'b1) begin
      if (exp_q.size() == 0) check("pop_unexpected", 64'(bus.DOUT), 64'hDEAD);
      else check("pop_data", 64'(bus.DOUT), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write cycle; the caller states whether the FIFO must accept it.
  task automatic write_word(input logic [W-1:0] d, input bit accepted);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = d;
    if (accepted) exp_q.push_back(d);
    step();
    bus.WR_EN = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    bus.DOUT_RDY = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_level0"}, 64'(bus.LEVEL), 64'd0);
    check({tag, "_vld0"}, 64'(bus.DOUT_VLD), 64'd0);
  endtask

  task automatic check_flags(input string tag, input int lvl);
`ifdef LUTRAM_FIFO_PROG_FLAGS_EN
    check({tag, "_ae"}, 64'(bus.ALMOST_EMPTY), 64'(lvl <= 2));
    check({tag, "_af"}, 64'(bus.ALMOST_FULL), 64'(lvl >= 30));
`else
    check({tag, "_ae"}, 64'(bus.ALMOST_EMPTY), 64'd0);
    check({tag, "_af"}, 64'(bus.ALMOST_FULL), 64'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.WR_EN    = 1'b0;
    bus.WR_DATA  = '0;
    bus.DOUT_RDY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 64'(bus.LEVEL), 64'd0);
    check("rst_vld", 64'(bus.DOUT_VLD), 64'd0);
    check("rst_full", 64'(bus.FULL), 64'd0);
    check("rst_ovf", 64'(bus.OVERFLOW), 64'd0);
    check("rst_dout", 64'(bus.DOUT), 64'd0);
    check_flags("rst", 0);
    rst = 1'b0;
    step();

    // T1: single word, latency one cycle after accept
    write_word(8'hA5, 1'b1);
    check("t1_level_after_accept", 64'(bus.LEVEL), 64'd1);
    check("t1_vld_after_accept", 64'(bus.DOUT_VLD), 64'd0);
    step();
    check("t1_vld", 64'(bus.DOUT_VLD), 64'd1);
    check("t1_dout", 64'(bus.DOUT), 64'hA5);
    check("t1_level", 64'(bus.LEVEL), 64'd1);
    check("t1_full", 64'(bus.FULL), 64'd0);
    drain("t1");
    bus.DOUT_RDY = 1'b0;

    // T2 + flags: fill 33 words, check LEVEL/flags at every step
    for (int i = 0; i < 33; i++) begin
      write_word(W'(i), 1'b1);
      check("t2_level", 64'(bus.LEVEL), 64'(i + 1));
      check("t2_full", 64'(bus.FULL), 64'(i == 32));
      check_flags("t2", i + 1);
    end
    check("t2_head", 64'(bus.DOUT), 64'h00);
    write_word(8'h55, 1'b0);
    check("t2_ovf", 64'(bus.OVERFLOW), 64'd1);
    check("t2_level_ovf", 64'(bus.LEVEL), 64'd33);
    check("t2_full_ovf", 64'(bus.FULL), 64'd1);
    step();
    check("t2_ovf_pulse", 64'(bus.OVERFLOW), 64'd0);
    check("t2_hold_dout", 64'(bus.DOUT), 64'h00);
    drain("t2");
    check_flags("t2_empty", 0);

    // T3: streaming 100 words with consumer always ready
    bus.DOUT_RDY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      write_word(W'(i), 1'b1);
      check("t3_level_le2", 64'(bus.LEVEL <= 6'd2), 64'd1);
      check("t3_full", 64'(bus.FULL), 64'd0);
    end
    drain("t3");

    // T4: reject a write while popping at LEVEL 33
    bus.DOUT_RDY = 1'b0;
    for (int i = 0; i < 33; i++) write_word(W'($urandom_range(0, 255)), 1'b1);
    check("t4_level33", 64'(bus.LEVEL), 64'd33);
    bus.DOUT_RDY = 1'b1;
    write_word(8'h77, 1'b0);
    bus.DOUT_RDY = 1'b0;
    check("t4_ovf", 64'(bus.OVERFLOW), 64'd1);
    check("t4_level32", 64'(bus.LEVEL), 64'd32);
    check("t4_full", 64'(bus.FULL), 64'd0);
    check("t4_vld", 64'(bus.DOUT_VLD), 64'd1);
    check("t4_next_head", 64'(bus.DOUT), 64'(exp_q[0]));
    drain("t4");

    // T5: asynchronous reset in mid-cycle
    bus.DOUT_RDY = 1'b0;
    for (int i = 0; i < 10; i++) write_word(W'($urandom_range(0, 255)), 1'b1);
    step();
    check("t5_level10", 64'(bus.LEVEL), 64'd10);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_level", 64'(bus.LEVEL), 64'd0);
    check("t5_rst_vld", 64'(bus.DOUT_VLD), 64'd0);
    check("t5_rst_dout", 64'(bus.DOUT), 64'd0);
    check("t5_rst_full", 64'(bus.FULL), 64'd0);
    check("t5_rst_ovf", 64'(bus.OVERFLOW), 64'd0);
    exp_q.delete();
    step();
    #2 rst = 1'b0;
    step();
    write_word(8'h3C, 1'b1);
    step();
    check("t5_first_out", 64'(bus.DOUT), 64'h3C);
    drain("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule
